// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and FSM state type.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned quotient/remainder core, including the
// divide-by-zero and most-negative/-1 overflow results.
module mdu_divider #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             is_signed_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             neg_a_s;
   logic             neg_b_s;
   logic [WIDTH-1:0] mag_a_s;
   logic [WIDTH-1:0] mag_b_s;
   logic [WIDTH-1:0] q_mag_s;
   logic [WIDTH-1:0] r_mag_s;

   // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
   always_comb begin
      neg_a_s = is_signed_i & dividend_i[WIDTH-1];
      neg_b_s = is_signed_i & divisor_i[WIDTH-1];
      mag_a_s = neg_a_s ? (~dividend_i + ONE) : dividend_i;
      mag_b_s = neg_b_s ? (~divisor_i + ONE) : divisor_i;
      if (mag_b_s == ZERO) begin
         q_mag_s = ZERO;
         r_mag_s = ZERO;
      end else begin
         q_mag_s = mag_a_s / mag_b_s;
         r_mag_s = mag_a_s % mag_b_s;
      end
      if (divisor_i == ZERO) begin
         quot_o = ALL_ONE;
         rem_o  = dividend_i;
      end else if (is_signed_i && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONE)) begin
         quot_o = MIN_NEG;
         rem_o  = ZERO;
      end else begin
         quot_o = (neg_a_s ^ neg_b_s) ? (~q_mag_s + ONE) : q_mag_s;
         rem_o  = neg_a_s ? (~r_mag_s + ONE) : r_mag_s;
      end
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; mthi/mtlo complete in one cycle,
// mult/div hold busy for a fixed cycle count and commit with a one-cycle done pulse.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               is_signed_s;
   logic [2*WIDTH-1:0] ext_a_s;
   logic [2*WIDTH-1:0] ext_b_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;

   // Even op codes (mult, div) are the signed variants.
   assign is_signed_s = ~op_q[0];
   assign ext_a_s     = {{WIDTH{is_signed_s & a_q[WIDTH-1]}}, a_q};
   assign ext_b_s     = {{WIDTH{is_signed_s & b_q[WIDTH-1]}}, b_q};
   assign prod_s      = ext_a_s * ext_b_s;

   mdu_divider #(.WIDTH(WIDTH)) u_divider (
      .dividend_i  (a_q),
      .divisor_i   (b_q),
      .is_signed_i (is_signed_s),
      .quot_o      (quot_s),
      .rem_o       (rem_s)
   );

   // Next-state: accept only when idle, count down while busy, commit on zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     state_d = BUSY;
                     cnt_d   = MULT_LOAD;
                     op_d    = op[1:0];
                     a_d     = src_a;
                     b_d     = src_b;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state_d = BUSY;
                     cnt_d   = DIV_LOAD;
                     op_d    = op[1:0];
                     a_d     = src_a;
                     b_d     = src_b;
                  end
                  MDU_MTHI: hi_d = src_a;
                  MDU_MTLO: lo_d = src_a;
                  default: ;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (op_q[1]) begin
                  hi_d = rem_s;
                  lo_d = quot_s;
               end else begin
                  hi_d = prod_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_s[WIDTH-1:0];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
         op_q    <= 2'b00;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == BUSY);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed and randomized operations against a
// plain-arithmetic reference model, plus busy-time, ignore-while-busy and async reset checks.
module tb_mdu_unit;

   localparam int W  = 32;
   localparam int NM = 5;
   localparam int ND = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int            n_tests;
   int            n_fail;
   logic [W-1:0]  old_hi;
   logic [W-1:0]  old_lo;

   mdu_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result {hi, lo} from the arithmetic definitions.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      longint      sp;
      int          ia;
      int          ib;
      ia = a;
      ib = b;
      r  = 64'd0;
      case (o)
         3'd0: begin
            sp = longint'(ia) * longint'(ib);
            r  = sp;
         end
         3'd1: r = {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 32'd0)
               r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = {32'd0, 32'h8000_0000};
            else
               r = {32'(ia % ib), 32'(ia / ib)};
         end
         3'd3: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {a % b, a / b};
         end
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      old_hi = hi;
      old_lo = lo;
      start  = 1'b1;
      op     = o;
      src_a  = a;
      src_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom_range(0, 7));
      src_a = $urandom;
      src_b = $urandom;
   endtask

   task automatic wait_done(input string name, input int cyc0, input int exp_n,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int cyc;
      int guard;
      bit hold_bad;
      cyc      = cyc0;
      guard    = 0;
      hold_bad = 1'b0;
      while (busy === 1'b1 && guard < 60) begin
         cyc++;
         guard++;
         if (hi !== old_hi || lo !== old_lo) hold_bad = 1'b1;
         if (done !== 1'b0) hold_bad = 1'b1;
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (cyc !== exp_n) begin
         n_fail++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_n);
      end
      n_tests++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL %s hold_while_busy: hi/lo or done changed during busy (got 1 expected 0)", name);
      end
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_pulse: got %b expected 1", name, done);
      end
      n_tests++;
      if (hi !== exp_hi || lo !== exp_lo) begin
         n_fail++;
         $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
         n_fail++;
         $display("FAIL %s after_done: got done=%b busy=%b hi=%h lo=%h expected 0 0 %h %h",
                  name, done, busy, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      src_a = '0;
      src_b = '0;
      #2;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_mult();
      launch(3'd0, 32'd3, 32'hFFFF_FFFE);
      wait_done("mult_dir", 0, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      launch(3'd1, 32'd3, 32'hFFFF_FFFE);
      wait_done("multu_dir", 0, NM, 32'h0000_0002, 32'hFFFF_FFFA);
   endtask

   task automatic test_div();
      launch(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_neg", 0, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 0, ND, 32'h0000_0000, 32'h8000_0000);
      launch(3'd3, 32'd5, 32'd0);
      wait_done("divu_zero", 0, ND, 32'h0000_0005, 32'hFFFF_FFFF);
      launch(3'd2, 32'hFFFF_FFF0, 32'd0);
      wait_done("div_zero", 0, ND, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] e;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         e = model(o, a, b);
         launch(o, a, b);
         wait_done($sformatf("rand%0d_op%0d", i, o), 0, (o < 3'd2) ? NM : ND, e[63:32], e[31:0]);
      end
   endtask

   task automatic test_ignore_while_busy();
      logic [63:0] e;
      e = model(3'd0, 32'h0000_1111, 32'hFFFF_FF00);
      launch(3'd0, 32'h0000_1111, 32'hFFFF_FF00);
      @(negedge clk);
      start = 1'b1;
      op    = 3'd5;
      src_a = 32'h0000_1234;
      @(posedge clk);
      #1;
      @(negedge clk);
      op    = 3'd0;
      src_a = 32'h7777_7777;
      src_b = 32'h0000_0003;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignore_busy", 2, NM, e[63:32], e[31:0]);
   endtask

   task automatic test_mthi_mtlo();
      logic [W-1:0] lo_prev;
      lo_prev = lo;
      @(negedge clk);
      start = 1'b1;
      op    = 3'd4;
      src_a = 32'h0000_ABCD;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_tests++;
      if (hi !== 32'h0000_ABCD || lo !== lo_prev || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b expected %h %h 0 0",
                  hi, lo, busy, done, 32'h0000_ABCD, lo_prev);
      end
      @(negedge clk);
      start = 1'b1;
      op    = 3'd5;
      src_a = 32'h5A5A_0001;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_tests++;
      if (lo !== 32'h5A5A_0001 || hi !== 32'h0000_ABCD || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mtlo: got hi=%h lo=%h busy=%b expected %h %h 0",
                  hi, lo, busy, 32'h0000_ABCD, 32'h5A5A_0001);
      end
      @(negedge clk);
      start = 1'b1;
      op    = 3'd6;
      src_a = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      op    = 3'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_tests++;
      if (lo !== 32'h5A5A_0001 || hi !== 32'h0000_ABCD || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL undefined_op: got hi=%h lo=%h busy=%b done=%b expected %h %h 0 0",
                  hi, lo, busy, done, 32'h0000_ABCD, 32'h5A5A_0001);
      end
   endtask

   task automatic test_reset_midop();
      bit stray;
      launch(3'd2, 32'h0000_0064, 32'h0000_0007);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_async: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < ND + 4; i++) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) stray = 1'b1;
      end
      n_tests++;
      if (stray) begin
         n_fail++;
         $display("FAIL reset_no_stale: stale activity after reset (got 1 expected 0), busy=%b done=%b hi=%h lo=%h",
                  busy, done, hi, lo);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      old_hi  = '0;
      old_lo  = '0;
      test_reset();
      test_mult();
      test_div();
      test_ignore_while_busy();
      test_mthi_mtlo();
      test_random();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the pipelined CPU generation.
- Sits beside the ALU in the EX stage.
- Executes mult/multu/div/divu over a configurable number of cycles and mthi/mtlo in one cycle.
- Exposes busy/done so the hazard logic can stall mfhi/mflo and further MDU ops.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu. Legal range is 1 or more.
- DIV_CYCLES, 10, busy cycles for div/divu. Legal range is 1 or more.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled on rising edge.
- op  input  3  operation code (see Decomposition).
- src_a  input  WIDTH  rs operand (dividend, multiplicand, mthi/mtlo data).
- src_b  input  WIDTH  rt operand (divisor, multiplier).
- busy  output  1  high while a mult/div is in progress.
- done  output  1  one-cycle pulse after HI/LO is updated by mult/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, any time, async):
  - busy=0, done=0, hi=0, lo=0, counter=0.
  - Any in-flight operation is discarded.
  - Outputs stay at these values until the first edge after reset returns to 1.
- Accept rule: start is accepted only on an edge where busy=0. Any start while busy=1, including mthi/mtlo, is ignored with no side effect. Undefined op codes are ignored.
- Operands src_a/src_b and op are captured at the accepting edge. Later input changes have no effect.
- mthi/mtlo:
  - hi (or lo) <= src_a at the accepting edge.
  - busy stays 0; done stays 0.
  - The new value is visible the next cycle.
- mult/multu/div/divu, accepted at edge k:
  - busy=1 from edge k through edge k+N, i.e. exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
  - hi/lo hold their old values while busy.
  - At edge k+N: hi/lo take the result, busy->0, done->1 for one cycle.
  - A new start may be accepted at edge k+N+1 or later (busy sampled 0).
- Arithmetic:
  - mult: signed 2WIDTH product, {hi,lo}.
  - multu: unsigned 2WIDTH product, {hi,lo}.
  - div: signed; lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): hi = src_a, lo = all ones.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- Internal datapath: the implementation may compute iteratively or combinationally, but the cycle-observable timing above is mandatory.
- FSM:
  - IDLE -> BUSY on an accepted mult/div; counter loaded with N-1.
  - BUSY: counter decrements each cycle. When counter=0, commit hi/lo and go to IDLE with done=1.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)).

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5.
  - state typedef {IDLE, BUSY}.
- One sub-module: mdu_divider, the signed/unsigned quotient/remainder core including the divide-by-zero and overflow rules. Multiplication stays inline.

Test Plan:
- mult, src_a=3, src_b=0xFFFFFFFE, defaults -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu, same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu, src_a=5, src_b=0 -> hi=0x00000005, lo=0xFFFFFFFF.
- mult accepted, then mtlo 0x1234 and a second mult issued while busy -> both ignored; only the first mult result lands. Then mthi 0xABCD with busy=0 -> hi=0xABCD next cycle, busy never rises.
- div in flight, reset pulled low mid-operation -> busy/done/hi/lo = 0 immediately (asynchronous). After release, no stale commit or done pulse occurs.
